// File: rtl/vtp_fail_log.sv
// VTP translation-failure recorder: per-port failure detection, staging,
// round-robin merge into a software-drained log, plus statistics CSRs.
module vtp_fail_log #(
    parameter int NUM_PORTS       = 2,
    parameter int ADDR_WIDTH      = 42,
    parameter int BURST_CNT_WIDTH = 7,
    parameter int LOG_DEPTH       = 16,
    parameter int CNT_WIDTH       = 16
) (
    input  logic                                 clk,
    input  logic                                 reset_n,
    input  logic [NUM_PORTS-1:0]                 rd_fail_valid,
    input  logic [NUM_PORTS*ADDR_WIDTH-1:0]      rd_fail_addr,
    input  logic [NUM_PORTS-1:0]                 wr_fail_valid,
    input  logic [NUM_PORTS*ADDR_WIDTH-1:0]      wr_fail_addr,
    input  logic [NUM_PORTS*BURST_CNT_WIDTH-1:0] wr_fail_burstcount,
    input  logic                                 clear_stats,
    input  logic                                 log_pop,
    output logic                                 log_valid,
    output logic                                 log_is_write,
    output logic [5:0]                           log_port,
    output logic [63:0]                          log_va,
    output logic [$clog2(LOG_DEPTH):0]           log_count,
    output logic [CNT_WIDTH-1:0]                 rd_fail_cnt,
    output logic [CNT_WIDTH-1:0]                 wr_fail_cnt,
    output logic [CNT_WIDTH-1:0]                 drop_cnt,
    output logic [63:0]                          last_rd_va,
    output logic [63:0]                          last_wr_va,
    output logic [63:0]                          first_fail_va,
    output logic                                 first_fail_valid
);

    localparam int NS = 2 * NUM_PORTS;
    localparam int PW = $clog2(NS);
    localparam int AW = $clog2(LOG_DEPTH);
    localparam int CW = AW + 1;
    localparam int SW = CNT_WIDTH + 8;
    localparam logic [CW-1:0] FULL = CW'(LOG_DEPTH);
    localparam logic [PW-1:0] LAST = PW'(NS - 1);

    function automatic logic [CNT_WIDTH-1:0] sat_add(
        input logic [CNT_WIDTH-1:0] a,
        input logic [7:0]           b
    );
        logic [SW-1:0] s;
        s = SW'(a) + SW'(b);
        if (s > SW'({CNT_WIDTH{1'b1}}))
            return '1;
        return s[CNT_WIDTH-1:0];
    endfunction

    function automatic logic [63:0] to_va(input logic [ADDR_WIDTH-1:0] a);
        return 64'(a) << 6;
    endfunction

    logic [BURST_CNT_WIDTH-1:0] rem [NUM_PORTS];
    logic [NUM_PORTS-1:0]       wr_sop;
    logic [NS-1:0]              ev;
    logic [NS-1:0]              drop;
    logic [NS-1:0]              gnt;
    logic [NS-1:0]              slot_v;
    logic [ADDR_WIDTH-1:0]      ev_addr [NS];
    logic [ADDR_WIDTH-1:0]      slot_addr [NS];
    logic [PW-1:0]              rr_ptr;
    logic [PW-1:0]              gnt_idx;
    logic                       gnt_any;
    logic [7:0]                 n_rd, n_wr, n_drop;
    logic                       rd_hit, wr_hit, first_hit;
    logic [ADDR_WIDTH-1:0]      rd_last, wr_last, first_addr;

    logic [ADDR_WIDTH-1:0]      f_addr [LOG_DEPTH];
    logic                       f_wr [LOG_DEPTH];
    logic [5:0]                 f_port [LOG_DEPTH];
    logic [AW-1:0]              wr_ptr, rd_ptr;
    logic                       push, pop;

    // Event detection; slot s = 2*port + is_write
    always_comb begin
        ev = '0;
        for (int p = 0; p < NUM_PORTS; p++) begin
            wr_sop[p] = wr_fail_valid[p] && (rem[p] == '0);
            ev[2*p] = rd_fail_valid[p];
            ev[2*p+1] = wr_sop[p];
            ev_addr[2*p] = rd_fail_addr[p*ADDR_WIDTH +: ADDR_WIDTH];
            ev_addr[2*p+1] = wr_fail_addr[p*ADDR_WIDTH +: ADDR_WIDTH];
        end
    end

    // Circular first-occupied search starting at the round-robin pointer
    always_comb begin
        int k;
        gnt = '0;
        gnt_idx = '0;
        gnt_any = 1'b0;
        k = 0;
        if (log_count != FULL) begin
            for (int i = 0; i < NS; i++) begin
                k = int'(rr_ptr) + i;
                if (k >= NS)
                    k = k - NS;
                if (!gnt_any && slot_v[k]) begin
                    gnt_any = 1'b1;
                    gnt_idx = PW'(k);
                end
            end
        end
        if (gnt_any)
            gnt[gnt_idx] = 1'b1;
    end

    always_comb begin
        n_rd = '0;
        n_wr = '0;
        n_drop = '0;
        rd_hit = 1'b0;
        wr_hit = 1'b0;
        first_hit = 1'b0;
        rd_last = '0;
        wr_last = '0;
        first_addr = '0;
        drop = '0;
        for (int s = 0; s < NS; s++) begin
            drop[s] = ev[s] && slot_v[s] && !gnt[s];
            if (drop[s])
                n_drop = n_drop + 8'd1;
            if (ev[s]) begin
                if (s % 2 == 0) begin
                    n_rd = n_rd + 8'd1;
                    rd_hit = 1'b1;
                    rd_last = ev_addr[s];
                end else begin
                    n_wr = n_wr + 8'd1;
                    wr_hit = 1'b1;
                    wr_last = ev_addr[s];
                end
                if (!first_hit) begin
                    first_hit = 1'b1;
                    first_addr = ev_addr[s];
                end
            end
        end
    end

    assign push = gnt_any;
    assign pop = log_pop && log_valid;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            for (int p = 0; p < NUM_PORTS; p++)
                rem[p] <= '0;
            slot_v <= '0;
            rr_ptr <= '0;
        end else begin
            for (int p = 0; p < NUM_PORTS; p++) begin
                if (wr_sop[p]) begin
                    if (wr_fail_burstcount[p*BURST_CNT_WIDTH +: BURST_CNT_WIDTH] == '0)
                        rem[p] <= '0;
                    else
                        rem[p] <= wr_fail_burstcount[p*BURST_CNT_WIDTH +: BURST_CNT_WIDTH]
                                  - BURST_CNT_WIDTH'(1);
                end else if (wr_fail_valid[p]) begin
                    rem[p] <= rem[p] - BURST_CNT_WIDTH'(1);
                end
            end
            for (int s = 0; s < NS; s++) begin
                if (ev[s] && (!slot_v[s] || gnt[s])) begin
                    slot_v[s] <= 1'b1;
                    slot_addr[s] <= ev_addr[s];
                end else if (gnt[s]) begin
                    slot_v[s] <= 1'b0;
                end
            end
            if (gnt_any)
                rr_ptr <= (gnt_idx == LAST) ? '0 : gnt_idx + PW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            log_count <= '0;
        end else begin
            if (push) begin
                f_addr[wr_ptr] <= slot_addr[gnt_idx];
                f_wr[wr_ptr] <= gnt_idx[0];
                f_port[wr_ptr] <= 6'(gnt_idx >> 1);
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (pop)
                rd_ptr <= rd_ptr + AW'(1);
            if (push && !pop)
                log_count <= log_count + CW'(1);
            else if (pop && !push)
                log_count <= log_count - CW'(1);
        end
    end

    assign log_valid = (log_count != '0);
    assign log_is_write = log_valid && f_wr[rd_ptr];
    assign log_port = log_valid ? f_port[rd_ptr] : '0;
    assign log_va = log_valid ? to_va(f_addr[rd_ptr]) : '0;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            rd_fail_cnt <= '0;
            wr_fail_cnt <= '0;
            drop_cnt <= '0;
            last_rd_va <= '0;
            last_wr_va <= '0;
            first_fail_va <= '0;
            first_fail_valid <= 1'b0;
        end else begin
            rd_fail_cnt <= sat_add(clear_stats ? '0 : rd_fail_cnt, n_rd);
            wr_fail_cnt <= sat_add(clear_stats ? '0 : wr_fail_cnt, n_wr);
            drop_cnt <= sat_add(clear_stats ? '0 : drop_cnt, n_drop);
            if (rd_hit)
                last_rd_va <= to_va(rd_last);
            if (wr_hit)
                last_wr_va <= to_va(wr_last);
            if (clear_stats) begin
                first_fail_valid <= 1'b0;
                first_fail_va <= '0;
            end
            // A same-cycle event lands after the clear
            if ((clear_stats || !first_fail_valid) && first_hit) begin
                first_fail_valid <= 1'b1;
                first_fail_va <= to_va(first_addr);
            end
        end
    end

endmodule

// File: tb/tb_vtp_fail_log.sv
// Scoreboard bench for vtp_fail_log: 2 ports, 16-entry log,
// 4-bit counters so saturation is reachable.
module tb_vtp_fail_log;

    localparam int NP = 2;
    localparam int AWD = 42;
    localparam int BW = 7;
    localparam int LD = 16;
    localparam int CWD = 4;

    typedef struct packed {
        logic        w;
        logic [5:0]  port;
        logic [63:0] va;
    } ent_t;

    logic                 clk;
    logic                 reset_n;
    logic [NP-1:0]        rd_fail_valid;
    logic [NP*AWD-1:0]    rd_fail_addr;
    logic [NP-1:0]        wr_fail_valid;
    logic [NP*AWD-1:0]    wr_fail_addr;
    logic [NP*BW-1:0]     wr_fail_burstcount;
    logic                 clear_stats;
    logic                 log_pop;
    logic                 log_valid;
    logic                 log_is_write;
    logic [5:0]           log_port;
    logic [63:0]          log_va;
    logic [4:0]           log_count;
    logic [CWD-1:0]       rd_fail_cnt;
    logic [CWD-1:0]       wr_fail_cnt;
    logic [CWD-1:0]       drop_cnt;
    logic [63:0]          last_rd_va;
    logic [63:0]          last_wr_va;
    logic [63:0]          first_fail_va;
    logic                 first_fail_valid;

    int   checks = 0;
    int   errors = 0;
    ent_t sb[$];

    vtp_fail_log #(
        .NUM_PORTS(NP), .ADDR_WIDTH(AWD), .BURST_CNT_WIDTH(BW),
        .LOG_DEPTH(LD), .CNT_WIDTH(CWD)
    ) dut (
        .clk(clk), .reset_n(reset_n),
        .rd_fail_valid(rd_fail_valid), .rd_fail_addr(rd_fail_addr),
        .wr_fail_valid(wr_fail_valid), .wr_fail_addr(wr_fail_addr),
        .wr_fail_burstcount(wr_fail_burstcount),
        .clear_stats(clear_stats), .log_pop(log_pop),
        .log_valid(log_valid), .log_is_write(log_is_write),
        .log_port(log_port), .log_va(log_va), .log_count(log_count),
        .rd_fail_cnt(rd_fail_cnt), .wr_fail_cnt(wr_fail_cnt),
        .drop_cnt(drop_cnt), .last_rd_va(last_rd_va),
        .last_wr_va(last_wr_va), .first_fail_va(first_fail_va),
        .first_fail_valid(first_fail_valid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h exp %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        rd_fail_valid = '0;
        wr_fail_valid = '0;
        clear_stats = 1'b0;
        log_pop = 1'b0;
    endtask

    task automatic set_rd(input int p, input logic [AWD-1:0] a);
        rd_fail_valid[p] = 1'b1;
        rd_fail_addr[p*AWD +: AWD] = a;
    endtask

    task automatic set_wr(input int p, input logic [AWD-1:0] a,
                          input logic [BW-1:0] bc);
        wr_fail_valid[p] = 1'b1;
        wr_fail_addr[p*AWD +: AWD] = a;
        wr_fail_burstcount[p*BW +: BW] = bc;
    endtask

    function automatic ent_t mk(input logic w, input int p,
                                input logic [AWD-1:0] a);
        ent_t e;
        e.w = w;
        e.port = 6'(p);
        e.va = 64'(a) << 6;
        return e;
    endfunction

    task automatic pop_check();
        ent_t e;
        int g;
        g = 0;
        while (!log_valid && g < 50) begin
            step();
            g++;
        end
        e = sb.pop_front();
        chk("head_valid", 64'(log_valid), 64'd1);
        if (log_valid) begin
            chk("head_wr", 64'(log_is_write), 64'(e.w));
            chk("head_port", 64'(log_port), 64'(e.port));
            chk("head_va", log_va, e.va);
            log_pop = 1'b1;
            step();
            log_pop = 1'b0;
        end
    endtask

    task automatic drain();
        while (sb.size() > 0)
            pop_check();
        step();
        chk("drain_empty", 64'(log_count), 64'd0);
    endtask

    initial begin
        reset_n = 1'b0;
        rd_fail_addr = '0;
        wr_fail_addr = '0;
        wr_fail_burstcount = '0;
        idle();
        step();
        step();
        reset_n = 1'b1;
        chk("rst_valid", 64'(log_valid), 64'd0);
        chk("rst_count", 64'(log_count), 64'd0);
        chk("rst_rdcnt", 64'(rd_fail_cnt), 64'd0);
        chk("rst_first", 64'(first_fail_valid), 64'd0);

        // Single read: latency and stats
        set_rd(0, 42'h100);
        sb.push_back(mk(1'b0, 0, 42'h100));
        step();
        idle();
        chk("lat_t1", 64'(log_valid), 64'd0);
        step();
        chk("lat_t2", 64'(log_valid), 64'd1);
        chk("rd_cnt1", 64'(rd_fail_cnt), 64'd1);
        chk("first_va", first_fail_va, 64'h4000);
        chk("first_v", 64'(first_fail_valid), 64'd1);
        drain();

        // 4-flit burst on port 1, then a 1-flit burst
        set_wr(1, 42'h200, 7'd4);
        sb.push_back(mk(1'b1, 1, 42'h200));
        step();
        for (int i = 0; i < 3; i++) begin
            set_wr(1, 42'h999, 7'd2);
            step();
        end
        idle();
        chk("burst_wrcnt", 64'(wr_fail_cnt), 64'd1);
        set_wr(1, 42'h300, 7'd1);
        sb.push_back(mk(1'b1, 1, 42'h300));
        step();
        idle();
        chk("sop_wrcnt", 64'(wr_fail_cnt), 64'd2);
        chk("last_wr", last_wr_va, 64'hC000);
        drain();

        // All four slots at once, then wrap check of the pointer
        set_rd(0, 42'h11);
        set_wr(0, 42'h12, 7'd1);
        set_rd(1, 42'h13);
        set_wr(1, 42'h14, 7'd0);
        sb.push_back(mk(1'b0, 0, 42'h11));
        sb.push_back(mk(1'b1, 0, 42'h12));
        sb.push_back(mk(1'b0, 1, 42'h13));
        sb.push_back(mk(1'b1, 1, 42'h14));
        step();
        idle();
        for (int i = 0; i < 4; i++)
            step();
        chk("all4_count", 64'(log_count), 64'd4);
        chk("all4_drop", 64'(drop_cnt), 64'd0);
        chk("last_rd_hi", last_rd_va, 64'(42'h13) << 6);
        chk("last_wr_hi", last_wr_va, 64'(42'h14) << 6);
        chk("first_sticky", first_fail_va, 64'h4000);
        set_rd(0, 42'h21);
        set_wr(1, 42'h22, 7'd1);
        sb.push_back(mk(1'b0, 0, 42'h21));
        sb.push_back(mk(1'b1, 1, 42'h22));
        step();
        idle();
        drain();

        // Clear alone keeps last VA
        clear_stats = 1'b1;
        step();
        idle();
        chk("clr_rdcnt", 64'(rd_fail_cnt), 64'd0);
        chk("clr_first", 64'(first_fail_valid), 64'd0);
        chk("clr_lastrd", last_rd_va, 64'(42'h21) << 6);

        // Fill the log, then overflow staging
        for (int i = 0; i < 16; i++) begin
            set_rd(0, 42'h1000 + 42'(i));
            sb.push_back(mk(1'b0, 0, 42'h1000 + 42'(i)));
            step();
        end
        idle();
        for (int i = 0; i < 3; i++)
            step();
        chk("full_count", 64'(log_count), 64'd16);
        for (int i = 0; i < 3; i++) begin
            set_rd(0, 42'h2000 + 42'(i));
            step();
        end
        sb.push_back(mk(1'b0, 0, 42'h2000));
        idle();
        step();
        chk("full_drop", 64'(drop_cnt), 64'd2);
        chk("full_count2", 64'(log_count), 64'd16);
        chk("rd_sat", 64'(rd_fail_cnt), 64'd15);
        pop_check();
        chk("pop_blocked", 64'(log_count), 64'd15);
        step();
        chk("pop_refill", 64'(log_count), 64'd16);
        drain();

        // Clear coincident with an event
        clear_stats = 1'b1;
        set_rd(1, 42'h3000);
        sb.push_back(mk(1'b0, 1, 42'h3000));
        step();
        idle();
        chk("clr_ev_rd", 64'(rd_fail_cnt), 64'd1);
        chk("clr_ev_drop", 64'(drop_cnt), 64'd0);
        chk("clr_ev_fv", 64'(first_fail_valid), 64'd1);
        chk("clr_ev_fva", first_fail_va, 64'(42'h3000) << 6);
        drain();

        // Reset in the middle of a burst
        set_wr(0, 42'h40, 7'd4);
        step();
        set_wr(0, 42'h41, 7'd4);
        step();
        idle();
        reset_n = 1'b0;
        step();
        reset_n = 1'b1;
        chk("mrst_valid", 64'(log_valid), 64'd0);
        chk("mrst_count", 64'(log_count), 64'd0);
        chk("mrst_wrcnt", 64'(wr_fail_cnt), 64'd0);
        chk("mrst_rdcnt", 64'(rd_fail_cnt), 64'd0);
        chk("mrst_drop", 64'(drop_cnt), 64'd0);
        chk("mrst_lastwr", last_wr_va, 64'd0);
        chk("mrst_lastrd", last_rd_va, 64'd0);
        chk("mrst_first", first_fail_va, 64'd0);
        chk("mrst_va", log_va, 64'd0);
        set_wr(0, 42'h80, 7'd1);
        sb.push_back(mk(1'b1, 0, 42'h80));
        step();
        idle();
        chk("mrst_sop", 64'(wr_fail_cnt), 64'd1);
        drain();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
